// File: rtl/fc_score_packer.sv
// Serial-to-parallel packer: collects N_CLASSES score words into one vector and
// holds it under a valid/ready handshake while the next frame streams in.
module fc_score_packer #(
  parameter int N_CLASSES  = 10,
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 320
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  frame_err
);

  localparam int CW = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_CLASSES - 1);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [DATA_WIDTH-1:0] col, col_d, col_next, odata_d;
  logic                  ovalid_d, ferr_d;
  logic                  accept;

  assign in_ready = (state == COLLECT);
  assign accept   = in_valid && in_ready;
  assign col_next = {col[DATA_WIDTH-WORD_WIDTH-1:0], in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      col       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      col       <= col_d;
      out_data  <= odata_d;
      out_valid <= ovalid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    col_d    = col;
    odata_d  = out_data;
    ovalid_d = out_valid;
    ferr_d   = 1'b0;
    // Consumption clears out_valid; a same-edge transfer below re-sets it.
    if (out_valid && out_ready) ovalid_d = 1'b0;
    case (state)
      COLLECT: begin
        if (flush) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt != LAST_IDX) begin
            if (in_last) begin
              ferr_d = 1'b1;
              cnt_d  = '0;
            end else begin
              col_d = col_next;
              cnt_d = cnt + 1'b1;
            end
          end else begin
            ferr_d = !in_last;
            col_d  = col_next;
            if (!out_valid || out_ready) begin
              odata_d  = col_next;
              ovalid_d = 1'b1;
              cnt_d    = '0;
            end else begin
              state_d = FULL;
            end
          end
        end
      end
      FULL: begin
        if (flush) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end else if (out_valid && out_ready) begin
          odata_d  = col;
          ovalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_fc_score_packer.sv
// Directed self-checking bench for fc_score_packer.
module tb_fc_score_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [319:0] out_data;
  logic         out_ready = 1'b1;
  logic         frame_err;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] f0w [10] = '{32'hbe808ea3, 32'hbe799d50, 32'h3e06b8ee, 32'h3c07c890,
                            32'hbe9d4b98, 32'h3e014309, 32'hbdb70839, 32'h3e29a92a,
                            32'h3d61ac73, 32'hbd7a5b46};
  logic [319:0] f0_exp = 320'hbe808ea3be799d503e06b8ee3c07c890be9d4b983e014309bdb708393e29a92a3d61ac73bd7a5b46;

  fc_score_packer #(.N_CLASSES(10), .WORD_WIDTH(32), .DATA_WIDTH(320)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wgen(input int unsigned f, input int unsigned k);
    return 32'h3f000000 + (32'(f) << 16) + 32'(k) * 32'h101;
  endfunction

  function automatic logic [319:0] pack(input int unsigned f);
    logic [319:0] v = '0;
    for (int unsigned k = 0; k < 10; k++) v = {v[287:0], wgen(f, k)};
    return v;
  endfunction

  // Float32 argmax via an order-preserving unsigned key.
  function automatic int argmax(input logic [319:0] v);
    logic [31:0] w, key, best = '0;
    int idx = 0;
    for (int k = 0; k < 10; k++) begin
      w   = v[319-32*k -: 32];
      key = w[31] ? ~w : (w | 32'h80000000);
      if (k == 0 || key > best) begin best = key; idx = k; end
    end
    return idx;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    in_valid = 1'b1; in_data = w; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int unsigned f);
    for (int unsigned k = 0; k < 10; k++) send(wgen(f, k), k == 9);
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_err", frame_err, 0);
    #3 rst_n = 1'b1;
    tick();

    // Reference frame, out_ready = 1
    for (int k = 0; k < 10; k++) begin
      send(f0w[k], k == 9);
      if (k == 8) check("f0_not_early", out_valid, 0);
    end
    check("f0_valid", out_valid, 1);
    check("f0_data", out_data, f0_exp);
    check("f0_err", frame_err, 0);
    check("f0_argmax", 320'(argmax(out_data)), 7);
    tick();
    check("f0_one_cycle", out_valid, 0);

    // Backpressure: A held, B parks in collect register
    out_ready = 1'b0;
    send_frame(1);
    check("a_valid", out_valid, 1);
    check("a_data", out_data, pack(1));
    for (int unsigned k = 0; k < 10; k++) begin
      send(wgen(2, k), k == 9);
      if (k == 4) check("a_stable_mid", out_data, pack(1));
    end
    check("b_full_in_ready", in_ready, 0);
    check("b_full_a_held", out_data, pack(1));
    tick();
    check("b_stall_in_ready", in_ready, 0);
    check("b_stall_a_held", out_data, pack(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b_data", out_data, pack(2));
    check("b_valid", out_valid, 1);
    check("b_in_ready", in_ready, 1);
    tick();
    check("b_held", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("b_consumed", out_valid, 0);

    // Three gapless frames
    for (int unsigned i = 0; i < 30; i++) begin
      check("b2b_in_ready", in_ready, 1);
      send(wgen(3 + i / 10, i % 10), (i % 10) == 9);
      if ((i % 10) == 9) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_data", out_data, pack(3 + i / 10));
      end else begin
        check("b2b_idle", out_valid, 0);
      end
    end
    tick();
    check("b2b_end", out_valid, 0);

    // Early in_last on word 4
    for (int unsigned k = 0; k < 4; k++) send(wgen(9, k), k == 3);
    check("early_err", frame_err, 1);
    check("early_no_out", out_valid, 0);
    tick();
    check("early_err_once", frame_err, 0);
    check("early_no_out2", out_valid, 0);
    send_frame(10);
    check("early_next_valid", out_valid, 1);
    check("early_next_data", out_data, pack(10));
    check("early_next_err", frame_err, 0);

    // Missing in_last on word 10: frame still delivered, error flagged
    for (int unsigned k = 0; k < 10; k++) send(wgen(11, k), 1'b0);
    check("nolast_valid", out_valid, 1);
    check("nolast_data", out_data, pack(11));
    check("nolast_err", frame_err, 1);
    tick();
    check("nolast_err_once", frame_err, 0);

    // Flush after 6 words with a concurrent word
    for (int unsigned k = 0; k < 6; k++) send(wgen(12, k), 1'b0);
    flush = 1'b1;
    send(32'hdeadbeef, 1'b0);
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    for (int unsigned k = 0; k < 10; k++) begin
      send(wgen(13, k), k == 9);
      if (k == 8) check("flush_not_early", out_valid, 0);
    end
    check("flush_valid", out_valid, 1);
    check("flush_data", out_data, pack(13));
    tick();
    check("flush_once", out_valid, 0);

    // Flush while FULL drops the parked frame, keeps the output
    out_ready = 1'b0;
    send_frame(14);
    send_frame(15);
    check("fflush_full", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fflush_in_ready", in_ready, 1);
    check("fflush_keep_valid", out_valid, 1);
    check("fflush_keep_data", out_data, pack(14));
    out_ready = 1'b1;
    tick();
    check("fflush_no_xfer", out_valid, 0);

    // Asynchronous reset mid-frame with out_valid high
    out_ready = 1'b0;
    send_frame(16);
    for (int unsigned k = 0; k < 4; k++) send(wgen(17, k), 1'b0);
    check("arst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_in_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int unsigned k = 0; k < 10; k++) begin
      send(wgen(18, k), k == 9);
      if (k == 8) check("arst_not_early", out_valid, 0);
    end
    check("arst_valid_new", out_valid, 1);
    check("arst_data_new", out_data, pack(18));
    tick();
    check("arst_once", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fc_score_packer.md
# fc_score_packer

Serial-to-parallel packer that sits between the fully-connected output layer and the combinational argmax stage. It accepts the ten IEEE-754 single-precision class scores one word per handshake and assembles them into the 320-bit score vector. It then holds that vector stable under a valid/ready handshake until the argmax/result logic consumes it. A separate collect register and output register let the next frame stream in while the previous vector is still held.

## Interface
- `N_CLASSES`, default 10: number of scores per frame.
- `WORD_WIDTH`, default 32: width of one score (IEEE-754 float32).
- `DATA_WIDTH`, default 320: output vector width; must equal `N_CLASSES*WORD_WIDTH`.
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous. Discards the partial frame in the collect register. Does not affect the output register.
- `in_valid`  in  1  upstream score word valid.
- `in_data`  in  `WORD_WIDTH`  score word.
- `in_last`  in  1  marks the word upstream believes is the last of the frame.
- `in_ready`  out  1  packer can accept a word this cycle.
- `out_valid`  out  1  `out_data` holds a complete frame.
- `out_data`  out  `DATA_WIDTH`  packed scores. Element k occupies bits `[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH]`, so element 0 is in the MSBs.
- `out_ready`  in  1  downstream accepts `out_data`.
- `frame_err`  out  1  one-cycle pulse for a malformed frame.

## Operation
- A word is accepted when `in_valid && in_ready`. Accepted words shift into the collect register: `col <= {col[DATA_WIDTH-WORD_WIDTH-1:0], in_data}`. After `N_CLASSES` words, the first word received sits in the MSBs.
- `cnt` runs from 0 to `N_CLASSES-1` and counts the words accepted in the current frame.
- States:
  - COLLECT: accepting words. On the accept with `cnt == N_CLASSES-1`, the full frame is complete.
    - If the output register is free (`!out_valid`, or `out_valid && out_ready` this cycle), `col_next` transfers to the output register in the same edge, `out_valid` sets to 1, `cnt` resets to 0, and the state stays COLLECT.
    - Otherwise the state moves to FULL.
  - FULL: collect register holds a complete frame; `in_ready` = 0. When the output register frees (`out_ready` while `out_valid`), the frame transfers, `cnt` resets to 0, and the state returns to COLLECT.
- `in_ready` = (state == COLLECT).
- `out_valid` clears on `out_valid && out_ready` unless a new transfer happens on the same edge. A same-edge transfer keeps it at 1 with the new data, allowing back-to-back frames.
- `out_data` changes only on a transfer. It is stable for as long as `out_valid && !out_ready`.
- `in_last` checking on each accepted word:
  - `in_last` = 1 with `cnt != N_CLASSES-1`: `frame_err` pulses, the partial frame is discarded (`cnt` resets to 0), and nothing transfers.
  - `in_last` = 0 with `cnt == N_CLASSES-1`: the frame is still accepted and transferred normally, and `frame_err` pulses.
- `flush`: in COLLECT, resets `cnt` to 0 and has priority over a word accepted in the same cycle; that word is dropped. In FULL, it discards the held frame and returns to COLLECT. It never clears `out_valid`.
- Data passes through unmodified: no float arithmetic and no NaN handling.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces: state = COLLECT, `cnt` = 0, `col` = 0, `out_data` = 0, `out_valid` = 0, `frame_err` = 0.
  - `in_ready` reads 1 as soon as reset is asserted.
  - Deasserting reset mid-frame never produces a partial vector.
- Latency: `out_valid` rises on the edge that accepts the 10th word, i.e. it is visible the cycle after that accept.
- Throughput: one word per cycle. With `out_ready` held at 1, frames are gapless and `out_valid` pulses for one cycle every 10 cycles.
- Backpressure: a second full frame stalls `in_ready` low from the cycle after its 10th word until the cycle after `out_ready` is seen.
- `frame_err` is registered and asserted for exactly one cycle, one cycle after the offending accept.

## Test plan
- Reset then stream, with `out_ready` = 1, the words be808ea3, be799d50, 3e06b8ee, 3c07c890, be9d4b98, 3e014309, bdb70839, 3e29a92a, 3d61ac73, bd7a5b46, with `in_last` on the last word.
  - Required: `out_valid` is 1 for one cycle, `out_data` = 320'hbe808ea3...bd7a5b46 in exactly that order, and `frame_err` = 0.
  - Feeding this `out_data` to the argmax stage must yield index 7.
- Hold `out_ready` = 0 and stream two frames A then B.
  - Required: A is held stable on `out_data`, and `in_ready` drops after B's 10th word.
  - Pulse `out_ready`: B appears the next cycle and `in_ready` returns to 1.
- Back-to-back streaming of 3 frames with `out_ready` = 1.
  - Required: 30 consecutive accepts with `in_ready` never 0, and 3 `out_valid` pulses 10 cycles apart.
- Assert `in_last` on word 4.
  - Required: `frame_err` pulses once and no output appears.
  - The next 10 words then form a correct frame.
- Assert `flush` after 6 words, including a cycle where `in_valid` = 1.
  - Required: the word in the flush cycle is dropped, and the following 10 words produce exactly one output vector.
- Assert `rst_n` low asynchronously between clock edges mid-frame and while `out_valid` = 1.
  - Required: `out_valid` = 0 and `out_data` = 0 immediately.
  - A fresh 10-word frame afterwards produces exactly one output vector.
